// File: rtl/cam_dvp_pkg.sv
// Shared types and timing helpers for the DVP camera source emulator.
package cam_dvp_pkg;

    typedef enum logic [2:0] {StIdle, StVsync, StVbp, StActive, StVfp} state_e;

    localparam int unsigned DEF_H_ACTIVE    = 40;
    localparam int unsigned DEF_V_ACTIVE    = 30;
    localparam int unsigned DEF_BPP         = 2;
    localparam int unsigned DEF_H_BLANK     = 16;
    localparam int unsigned DEF_VSYNC_LINES = 3;
    localparam int unsigned DEF_VBP_LINES   = 2;
    localparam int unsigned DEF_VFP_LINES   = 2;

    function automatic int unsigned line_len(int unsigned h_active, int unsigned bpp,
                                             int unsigned h_blank);
        return h_active * bpp + h_blank;
    endfunction

    function automatic int unsigned frame_len(int unsigned line_ticks, int unsigned vs_lines,
                                              int unsigned vbp_lines, int unsigned va_lines,
                                              int unsigned vfp_lines);
        return line_ticks * (vs_lines + vbp_lines + va_lines + vfp_lines);
    endfunction

    function automatic int unsigned max_u(int unsigned a, int unsigned b);
        return (a > b) ? a : b;
    endfunction

    // Bits needed to hold 0..n-1, never less than one.
    function automatic int unsigned cnt_w(int unsigned n);
        return (n <= 1) ? 1 : int'($clog2(n));
    endfunction

endpackage

// File: rtl/cam_dvp_source_if.sv
// DVP sensor-side bus: pixel clock, frame/line sync and 8-bit data.
interface cam_dvp_source_if;
    logic       cam_pclk;
    logic       cam_vsync;
    logic       cam_href;
    logic [7:0] cam_dat;

    modport master (output cam_pclk, cam_vsync, cam_href, cam_dat);
    modport slave  (input  cam_pclk, cam_vsync, cam_href, cam_dat);
endinterface

// File: rtl/cam_dvp_pattern.sv
// Test-pattern byte generator; kept separate so other patterns can be dropped in.
module cam_dvp_pattern #(
    parameter int unsigned ColW  = 7,
    parameter int unsigned LineW = 5
) (
    input  logic [ColW-1:0]  col_i,
    input  logic [LineW-1:0] line_i,
    input  logic [7:0]       foff_i,
    output logic [7:0]       dat_o
);
    always_comb dat_o = 8'(col_i) + 8'(line_i) + foff_i;
endmodule

// File: rtl/cam_dvp_source.sv
// OV7670-style DVP sensor emulator producing a deterministic RGB565 byte pattern.
// Define CAM_DVP_SOURCE_FRAME_OFFSET_EN to shift the pattern by a per-frame counter.
module cam_dvp_source
    import cam_dvp_pkg::*;
#(
    parameter int unsigned H_ACTIVE    = DEF_H_ACTIVE,
    parameter int unsigned V_ACTIVE    = DEF_V_ACTIVE,
    parameter int unsigned BPP         = DEF_BPP,
    parameter int unsigned H_BLANK     = DEF_H_BLANK,
    parameter int unsigned VSYNC_LINES = DEF_VSYNC_LINES,
    parameter int unsigned VBP_LINES   = DEF_VBP_LINES,
    parameter int unsigned VFP_LINES   = DEF_VFP_LINES
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             enable,
    cam_dvp_source_if.master dvp,
    output logic             busy,
    output logic             frame_done
);
    localparam int unsigned HB       = H_ACTIVE * BPP;
    localparam int unsigned L        = line_len(H_ACTIVE, BPP, H_BLANK);
    localparam int unsigned MaxLines = max_u(max_u(VSYNC_LINES, VBP_LINES),
                                             max_u(V_ACTIVE, VFP_LINES));
    localparam int unsigned ColW     = cnt_w(L);
    localparam int unsigned LineW    = cnt_w(MaxLines);

    function automatic int unsigned lines_of(state_e s);
        case (s)
            StVsync:  return VSYNC_LINES;
            StVbp:    return VBP_LINES;
            StActive: return V_ACTIVE;
            StVfp:    return VFP_LINES;
            default:  return 0;
        endcase
    endfunction

    // Zero-length phases are passed over in the same tick.
    function automatic state_e skip_empty(state_e s);
        state_e r;
        r = s;
        if (r == StVsync && VSYNC_LINES == 0) r = StVbp;
        if (r == StVbp && VBP_LINES == 0) r = StActive;
        if (r == StActive && V_ACTIVE == 0) r = StVfp;
        if (r == StVfp && VFP_LINES == 0) r = StIdle;
        return r;
    endfunction

    logic             ph_q, ph_d;
    state_e           state_q, state_d;
    logic [ColW-1:0]  col_q, col_d;
    logic [LineW-1:0] line_q, line_d;
    logic             vsync_q, vsync_d, href_q, href_d;
    logic [7:0]       dat_q, dat_d, pat;
    logic             busy_q, busy_d, done_q, done_d;
    logic [7:0]       foff;
    logic             tick, line_end, state_end;

`ifdef CAM_DVP_SOURCE_FRAME_OFFSET_EN
    logic [7:0] fcnt_q, fcnt_d;

    assign fcnt_d = done_d ? fcnt_q + 8'd1 : fcnt_q;
    assign foff   = fcnt_q;

    always_ff @(posedge clk) begin
        if (!resetn) fcnt_q <= '0;
        else         fcnt_q <= fcnt_d;
    end
`else
    assign foff = 8'd0;
`endif

    always_comb begin
        ph_d      = ~ph_q;
        tick      = ph_q;
        state_d   = state_q;
        col_d     = col_q;
        line_d    = line_q;
        vsync_d   = vsync_q;
        href_d    = href_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        line_end  = (32'(col_q) == L - 1);
        state_end = line_end && (32'(line_q) == lines_of(state_q) - 1);
        if (tick) begin
            unique case (state_q)
                StIdle:   if (enable) state_d = skip_empty(StVsync);
                StVsync:  if (state_end) state_d = skip_empty(StVbp);
                StVbp:    if (state_end) state_d = skip_empty(StActive);
                StActive: if (state_end) state_d = skip_empty(StVfp);
                StVfp:    if (state_end) state_d = StIdle;
                default:  state_d = StIdle;
            endcase
            if (state_d != state_q || state_q == StIdle) begin
                col_d  = '0;
                line_d = '0;
            end else if (line_end) begin
                col_d  = '0;
                line_d = line_q + LineW'(1);
            end else begin
                col_d = col_q + ColW'(1);
            end
            vsync_d = (state_d == StVsync);
            href_d  = (state_d == StActive) && (32'(col_d) < HB);
            busy_d  = (state_d != StIdle);
            done_d  = (state_q != StIdle) && (state_d == StIdle);
        end
    end

    cam_dvp_pattern #(
        .ColW  (ColW),
        .LineW (LineW)
    ) u_pattern (
        .col_i  (col_d),
        .line_i (line_d),
        .foff_i (foff),
        .dat_o  (pat)
    );

    assign dat_d = href_d ? pat : 8'd0;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            ph_q    <= 1'b0;
            state_q <= StIdle;
            col_q   <= '0;
            line_q  <= '0;
            vsync_q <= 1'b0;
            href_q  <= 1'b0;
            dat_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            ph_q    <= ph_d;
            state_q <= state_d;
            col_q   <= col_d;
            line_q  <= line_d;
            vsync_q <= vsync_d;
            href_q  <= href_d;
            dat_q   <= dat_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign dvp.cam_pclk  = ph_q;
    assign dvp.cam_vsync = vsync_q;
    assign dvp.cam_href  = href_q;
    assign dvp.cam_dat   = dat_q;
    assign busy          = busy_q;
    assign frame_done    = done_q;

endmodule

// File: tb/tb_cam_dvp_source.sv
// Bench for cam_dvp_source: scoreboard of expected href bytes plus frame timing checks.
module tb_cam_dvp_source;
    localparam int HA_BYTES   = 80;
    localparam int VA         = 30;
    localparam int VS_CLKS    = 576;
    localparam int FRAME_CLKS = 7104;
`ifdef CAM_DVP_SOURCE_FRAME_OFFSET_EN
    localparam logic [7:0] FOFF_MASK = 8'hFF;
`else
    localparam logic [7:0] FOFF_MASK = 8'h00;
`endif

    logic clk = 1'b0;
    logic resetn = 1'b0;
    logic enable = 1'b0;
    logic busy, frame_done;

    cam_dvp_source_if dvp ();

    cam_dvp_source u_dut (
        .clk        (clk),
        .resetn     (resetn),
        .enable     (enable),
        .dvp        (dvp),
        .busy       (busy),
        .frame_done (frame_done)
    );

    logic [7:0] p_col, p_foff, p_dat;
    logic [4:0] p_line;

    cam_dvp_pattern #(
        .ColW  (8),
        .LineW (5)
    ) u_pat (
        .col_i  (p_col),
        .line_i (p_line),
        .foff_i (p_foff),
        .dat_o  (p_dat)
    );

    int         n_cmp = 0;
    int         n_fail = 0;
    int         cyc = 0;
    int         exp_frames = 0;
    logic [7:0] sb[$];
    logic [7:0] exp_b;
    bit         mon_on = 1'b0;
    int         run_len = 0, href_runs = 0, vs_rises = 0, fd_cnt = 0;
    int         vs_rise_cyc = 0, vs_fall_cyc = 0, fd_cyc = 0, busy_fall_cyc = 0;
    logic       vs_rise_pclk = 1'b1, vs_prev = 1'b0, busy_prev = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog");
    end

    task automatic push_frame(input logic [7:0] foff);
        for (int ln = 0; ln < VA; ln++)
            for (int c = 0; c < HA_BYTES; c++) sb.push_back(8'(c + ln) + foff);
    endtask

    // Receiver view: one sample per pclk period, taken while pclk is high.
    task automatic monitor();
        forever begin
            @(negedge clk);
            if (mon_on) begin
                if (dvp.cam_vsync && !vs_prev) begin
                    vs_rises++;
                    vs_rise_cyc  = cyc;
                    vs_rise_pclk = dvp.cam_pclk;
                end
                if (!dvp.cam_vsync && vs_prev) vs_fall_cyc = cyc;
                if (!busy && busy_prev) busy_fall_cyc = cyc;
                if (frame_done) begin
                    fd_cnt++;
                    fd_cyc = cyc;
                end
                if (dvp.cam_pclk) begin
                    if (dvp.cam_href) begin
                        run_len++;
                        n_cmp++;
                        if (sb.size() == 0) begin
                            n_fail++;
                            $display("FAIL sb_underflow: got byte %0d, none expected", dvp.cam_dat);
                        end else begin
                            exp_b = sb.pop_front();
                            if (dvp.cam_dat !== exp_b) begin
                                n_fail++;
                                $display("FAIL pixel_byte: got %0d, want %0d (run %0d byte %0d)",
                                         dvp.cam_dat, exp_b, href_runs, run_len - 1);
                            end
                        end
                    end else begin
                        if (run_len != 0) begin
                            n_cmp++;
                            if (run_len != HA_BYTES) begin
                                n_fail++;
                                $display("FAIL href_run_len: got %0d, want %0d", run_len, HA_BYTES);
                            end
                            href_runs++;
                            run_len = 0;
                        end
                        n_cmp++;
                        if (dvp.cam_dat !== 8'h00) begin
                            n_fail++;
                            $display("FAIL blank_dat: got %0d, want 0", dvp.cam_dat);
                        end
                    end
                end
            end
            vs_prev   = dvp.cam_vsync;
            busy_prev = busy;
        end
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        enable = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if ({dvp.cam_pclk, dvp.cam_vsync, dvp.cam_href, busy, frame_done} !== 5'b0 ||
            dvp.cam_dat !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_outputs: got pclk=%b vs=%b href=%b dat=%0d busy=%b fd=%b, want all 0",
                     dvp.cam_pclk, dvp.cam_vsync, dvp.cam_href, dvp.cam_dat, busy, frame_done);
        end
        resetn = 1'b1;
        @(posedge clk);
        #1;
        n_cmp++;
        if (dvp.cam_pclk !== 1'b1) begin
            n_fail++;
            $display("FAIL pclk_rise: got %b, want 1", dvp.cam_pclk);
        end
        @(posedge clk);
        #1;
        n_cmp++;
        if (dvp.cam_pclk !== 1'b0) begin
            n_fail++;
            $display("FAIL pclk_fall: got %b, want 0", dvp.cam_pclk);
        end
        mon_on = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        n_cmp++;
        if ({dvp.cam_vsync, dvp.cam_href, busy, frame_done} !== 4'b0) begin
            n_fail++;
            $display("FAIL idle_outputs: got vs=%b href=%b busy=%b fd=%b, want 0",
                     dvp.cam_vsync, dvp.cam_href, busy, frame_done);
        end
    endtask

    task automatic test_single_frame();
        int t0, fd0, rise0;
        push_frame(8'(exp_frames) & FOFF_MASK);
        href_runs = 0;
        fd0       = fd_cnt;
        rise0     = vs_rises;
        @(posedge clk);
        #1;
        enable = 1'b1;
        t0     = cyc;
        while (vs_rises == rise0 && cyc - t0 < 8) begin @(posedge clk); #1; end
        enable = 1'b0;
        n_cmp++;
        if (vs_rises == rise0 || vs_rise_cyc - t0 < 1 || vs_rise_cyc - t0 > 2) begin
            n_fail++;
            $display("FAIL vsync_start: got latency %0d clk (rises %0d), want 1..2",
                     vs_rise_cyc - t0, vs_rises - rise0);
        end
        n_cmp++;
        if (vs_rise_pclk !== 1'b0) begin
            n_fail++;
            $display("FAIL vsync_on_tick: pclk=%b at vsync rise, want 0", vs_rise_pclk);
        end
        n_cmp++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL busy_high: got %b, want 1", busy);
        end
        t0 = cyc;
        while (fd_cnt == fd0 && cyc - t0 < FRAME_CLKS + 100) begin @(posedge clk); #1; end
        repeat (4) @(posedge clk);
        #1;
        exp_frames++;
        n_cmp++;
        if (fd_cnt - fd0 != 1) begin
            n_fail++;
            $display("FAIL frame_done_count: got %0d, want 1", fd_cnt - fd0);
        end
        n_cmp++;
        if (fd_cyc - vs_rise_cyc != FRAME_CLKS) begin
            n_fail++;
            $display("FAIL frame_len: got %0d clk, want %0d", fd_cyc - vs_rise_cyc, FRAME_CLKS);
        end
        n_cmp++;
        if (busy_fall_cyc != fd_cyc) begin
            n_fail++;
            $display("FAIL busy_fall: got cyc %0d, want %0d", busy_fall_cyc, fd_cyc);
        end
        n_cmp++;
        if (vs_fall_cyc - vs_rise_cyc != VS_CLKS) begin
            n_fail++;
            $display("FAIL vsync_len: got %0d clk, want %0d", vs_fall_cyc - vs_rise_cyc, VS_CLKS);
        end
        n_cmp++;
        if (href_runs != VA || sb.size() != 0) begin
            n_fail++;
            $display("FAIL href_runs: got %0d runs, %0d bytes left, want %0d runs, 0 left",
                     href_runs, sb.size(), VA);
        end
    endtask

    task automatic test_back_to_back();
        int t0, fd0, rise0;
        for (int k = 0; k < 3; k++) push_frame(8'(exp_frames + k) & FOFF_MASK);
        href_runs = 0;
        fd0       = fd_cnt;
        rise0     = vs_rises;
        @(posedge clk);
        #1;
        enable = 1'b1;
        t0     = cyc;
        for (int k = 0; k < 3; k++) begin
            while (fd_cnt == fd0 + k && cyc - t0 < 4 * FRAME_CLKS) begin @(posedge clk); #1; end
            if (k < 2) begin
                while (vs_rises == rise0 + k + 1 && cyc - t0 < 4 * FRAME_CLKS) begin
                    @(posedge clk);
                    #1;
                end
                n_cmp++;
                if (vs_rise_cyc - fd_cyc != 2) begin
                    n_fail++;
                    $display("FAIL frame_gap: got %0d clk, want 2", vs_rise_cyc - fd_cyc);
                end
                if (k == 1) enable = 1'b0;
            end
        end
        repeat (4) @(posedge clk);
        #1;
        exp_frames += 3;
        n_cmp++;
        if (fd_cnt - fd0 != 3 || href_runs != 3 * VA || sb.size() != 0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL back_to_back: got fd=%0d runs=%0d left=%0d busy=%b, want 3 %0d 0 0",
                     fd_cnt - fd0, href_runs, sb.size(), busy, 3 * VA);
        end
    endtask

    task automatic test_enable_drop();
        int t0, fd0, bad;
        push_frame(8'(exp_frames) & FOFF_MASK);
        href_runs = 0;
        fd0       = fd_cnt;
        @(posedge clk);
        #1;
        enable = 1'b1;
        t0     = cyc;
        while (!(href_runs == 10 && dvp.cam_href) && cyc - t0 < FRAME_CLKS) begin
            @(posedge clk);
            #1;
        end
        enable = 1'b0;
        n_cmp++;
        if (href_runs != 10 || dvp.cam_href !== 1'b1) begin
            n_fail++;
            $display("FAIL reach_line10: got runs=%0d href=%b, want 10 and 1", href_runs, dvp.cam_href);
        end
        while (fd_cnt == fd0 && cyc - t0 < 2 * FRAME_CLKS) begin @(posedge clk); #1; end
        exp_frames++;
        bad = 0;
        repeat (1000) begin
            @(posedge clk);
            #1;
            if ({dvp.cam_vsync, dvp.cam_href, busy, frame_done} !== 4'b0 || dvp.cam_dat !== 8'h00)
                bad++;
        end
        n_cmp++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL idle_after_drop: got %0d active clks, want 0", bad);
        end
        n_cmp++;
        if (fd_cnt - fd0 != 1 || href_runs != VA || sb.size() != 0) begin
            n_fail++;
            $display("FAIL drop_frame: got fd=%0d runs=%0d left=%0d, want 1 %0d 0",
                     fd_cnt - fd0, href_runs, sb.size(), VA);
        end
    endtask

    task automatic test_reset_mid();
        int t0;
        push_frame(8'(exp_frames) & FOFF_MASK);
        href_runs = 0;
        @(posedge clk);
        #1;
        enable = 1'b1;
        t0     = cyc;
        while (href_runs < 3 && cyc - t0 < FRAME_CLKS) begin @(posedge clk); #1; end
        mon_on = 1'b0;
        resetn = 1'b0;
        @(posedge clk);
        #1;
        n_cmp++;
        if ({dvp.cam_pclk, dvp.cam_vsync, dvp.cam_href, busy, frame_done} !== 5'b0 ||
            dvp.cam_dat !== 8'h00) begin
            n_fail++;
            $display("FAIL mid_reset: got pclk=%b vs=%b href=%b dat=%0d busy=%b, want all 0",
                     dvp.cam_pclk, dvp.cam_vsync, dvp.cam_href, dvp.cam_dat, busy);
        end
        resetn = 1'b1;
        enable = 1'b0;
        sb.delete();
        run_len    = 0;
        exp_frames = 0;
        repeat (3) @(posedge clk);
        #1;
        mon_on = 1'b1;
        test_single_frame();
    endtask

    task automatic test_pattern();
        logic [7:0] vc[4] = '{8'd200, 8'd0, 8'd79, 8'd255};
        logic [4:0] vl[4] = '{5'd29, 5'd0, 5'd29, 5'd31};
        logic [7:0] vf[4] = '{8'd255, 8'd0, 8'd0, 8'd255};
        logic [7:0] ve[4] = '{8'd228, 8'd0, 8'd108, 8'd29};
        logic [7:0] exp;
        for (int i = 0; i < 12; i++) begin
            if (i < 4) begin
                p_col  = vc[i];
                p_line = vl[i];
                p_foff = vf[i];
                exp    = ve[i];
            end else begin
                p_col  = 8'($urandom_range(0, 255));
                p_line = 5'($urandom_range(0, 31));
                p_foff = 8'($urandom_range(0, 255));
                exp    = 8'((int'(p_col) + int'(p_line) + int'(p_foff)) % 256);
            end
            #1;
            n_cmp++;
            if (p_dat !== exp) begin
                n_fail++;
                $display("FAIL pattern: col=%0d line=%0d foff=%0d got %0d, want %0d",
                         p_col, p_line, p_foff, p_dat, exp);
            end
        end
    endtask

    initial begin
        fork
            monitor();
        join_none
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_enable_drop();
        test_reset_mid();
        test_pattern();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
